// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
package mem_arb_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_timeout.sv
// Response timeout counter: synchronous clear, count enable, saturating.
// expired_o is high while the count sits at TIMEOUT_CYC-1, i.e. during
// the TIMEOUT_CYC-th enabled cycle after a clear.
module mem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment when enabled, holding at saturation.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable_i && (count_q != CNT_SAT)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ready/valid memory port between instruction fetch and load/store.
// One transaction at a time, data requests win over fetch, with a response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic                i_err,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_done,
    output logic                d_err,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                stall
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e          state_q,   state_d;
    arb_owner_e          owner_q,   owner_d;
    logic                m_valid_q, m_valid_d;
    logic                m_we_q,    m_we_d;
    logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
    logic                i_done_q,  i_done_d;
    logic                i_err_q,   i_err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic                d_done_q,  d_done_d;
    logic                d_err_q,   d_err_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic                tmr_clear;
    logic                tmr_en;
    logic                tmr_expired;
    logic                resp_fire;
    logic                resp_err;
    logic [DATA_W-1:0]   resp_data;

    mem_arb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next-state, request latch and completion logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_valid_d = m_valid_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        resp_data = {DATA_W{1'b0}};

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    owner_d   = OWN_DATA;
                    m_valid_d = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_wstrb_d = d_we ? d_wstrb : {STRB_W{1'b0}};
                    state_d   = ISSUE;
                end else if (i_req) begin
                    owner_d   = OWN_FETCH;
                    m_valid_d = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = {DATA_W{1'b0}};
                    m_wstrb_d = {STRB_W{1'b0}};
                    state_d   = ISSUE;
                end else begin
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    tmr_clear = 1'b1;
                    state_d   = WAIT;
                end else begin
                    m_valid_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    resp_fire = 1'b1;
                    resp_data = m_we_q ? {DATA_W{1'b0}} : m_rdata;
                    state_d   = DONE;
                end else if (tmr_expired) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmr_en    = 1'b1;
                    state_d   = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        endcase

        // Completion is steered to the owner; done/err last only the DONE cycle,
        // read data is held until the owner's next completion.
        i_done_d  = resp_fire & (owner_q == OWN_FETCH);
        d_done_d  = resp_fire & (owner_q == OWN_DATA);
        i_err_d   = i_done_d & resp_err;
        d_err_d   = d_done_d & resp_err;
        i_rdata_d = i_done_d ? resp_data : i_rdata_q;
        d_rdata_d = d_done_d ? resp_data : d_rdata_q;
    end

    // State and output registers; reset returns to IDLE with every output low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_FETCH;
            m_valid_q <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= {ADDR_W{1'b0}};
            m_wdata_q <= {DATA_W{1'b0}};
            m_wstrb_q <= {STRB_W{1'b0}};
            i_done_q  <= 1'b0;
            i_err_q   <= 1'b0;
            i_rdata_q <= {DATA_W{1'b0}};
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            m_valid_q <= m_valid_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            i_done_q  <= i_done_d;
            i_err_q   <= i_err_d;
            i_rdata_q <= i_rdata_d;
            d_done_q  <= d_done_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign i_done  = i_done_q;
    assign i_err   = i_err_q;
    assign i_rdata = i_rdata_q;
    assign d_done  = d_done_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;

    // The core is held until every raised request has seen its completion pulse.
    assign stall = (i_req & ~i_done_q) | (d_req & ~d_done_q);

endmodule
